// File: rtl/text_memory_loader.sv
// text_memory_loader
// Boot-time writer for the program text memory. Consumes a framed
// little-endian byte stream (length, payload words, checksum), writes the
// payload words sequentially from BASE_ADDR and holds the core in reset until
// a complete image with a good checksum has been loaded.
module text_memory_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        start,
    output logic        wr_en,
    output logic [31:0] wr_address,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_LENGTH   = 2'b01;
    localparam logic [1:0] ERR_CHECKSUM = 2'b10;

    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_DATA  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    // Frame-tracking state.
    state_t      state_q,    state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;   // byte position inside length/word
    logic [31:0] word_idx_q, word_idx_d;   // words written this frame
    logic [31:0] len_q,      len_d;        // length field being assembled / held
    logic [31:0] word_q,     word_d;       // payload word being assembled
    logic [7:0]  csum_q,     csum_d;       // running payload byte sum

    // Registered outputs.
    logic        wr_en_q,      wr_en_d;
    logic [31:0] wr_address_q, wr_address_d;
    logic [31:0] wr_data_q,    wr_data_d;
    logic        cpu_hold_q,   cpu_hold_d;
    logic        done_q,       done_d;
    logic        error_q,      error_d;
    logic [1:0]  err_code_q,   err_code_d;

    // Combinational helpers.
    logic        accept;
    logic        last_byte;
    logic [31:0] len_full;
    logic [31:0] word_full;
    logic [31:0] word_idx_inc;

    // Ready depends only on state: everything except DONE takes bytes
    // (ERROR takes them so a stuck sender drains, but throws them away).
    always_comb begin
        case (state_q)
            S_DONE:  in_ready = 1'b0;
            default: in_ready = 1'b1;
        endcase
    end

    // Byte-stream helpers shared by the length and payload phases.
    always_comb begin
        accept       = in_valid && in_ready;
        last_byte    = (byte_cnt_q == 2'd3);
        // Shifting each new byte in at the top places byte k at [8k+7:8k]
        // once all four have arrived.
        len_full     = {in_data, len_q[31:8]};
        word_full    = {in_data, word_q[31:8]};
        word_idx_inc = word_idx_q + 32'd1;
    end

    // Next-state, datapath and output logic.
    always_comb begin
        // NOTE: every _d starts at its held value (wr_en_d at 0, since it is a
        // strobe) so no path through the case statement can infer a latch.
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_idx_d   = word_idx_q;
        len_d        = len_q;
        word_d       = word_q;
        csum_d       = csum_q;
        wr_en_d      = 1'b0;
        wr_address_d = wr_address_q;
        wr_data_d    = wr_data_q;
        cpu_hold_d   = cpu_hold_q;
        done_d       = done_q;
        error_d      = error_q;
        err_code_d   = err_code_q;

        case (state_q)
            S_LEN: begin
                if (accept) begin
                    len_d      = len_full;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (last_byte) begin
                        if (len_full > MAX_LEN) begin
                            state_d    = S_ERROR;
                            error_d    = 1'b1;
                            err_code_d = ERR_LENGTH;
                        end else if (len_full == 32'd0) begin
                            state_d = S_CHECK;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    word_d     = word_full;
                    csum_d     = csum_q + in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (last_byte) begin
                        wr_en_d      = 1'b1;
                        wr_address_d = BASE_ADDR + (word_idx_q << 2);
                        wr_data_d    = word_full;
                        word_idx_d   = word_idx_inc;
                        if (word_idx_inc == len_q) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end

            S_CHECK: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = ERR_CHECKSUM;
                    end
                end
            end

            S_DONE: begin
                if (start) begin
                    state_d    = S_LEN;
                    byte_cnt_d = 2'd0;
                    word_idx_d = 32'd0;
                    len_d      = 32'd0;
                    word_d     = 32'd0;
                    csum_d     = 8'd0;
                    done_d     = 1'b0;
                    cpu_hold_d = 1'b1;
                end
            end

            S_ERROR: begin
                // Accepted bytes are dropped; only start leaves this state.
                if (start) begin
                    state_d    = S_LEN;
                    byte_cnt_d = 2'd0;
                    word_idx_d = 32'd0;
                    len_d      = 32'd0;
                    word_d     = 32'd0;
                    csum_d     = 8'd0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                end
            end

            default: begin
                state_d = S_LEN;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values of the others, independent of statement order.
        if (reset) begin
            state_q      <= S_LEN;
            byte_cnt_q   <= 2'd0;
            word_idx_q   <= 32'd0;
            len_q        <= 32'd0;
            word_q       <= 32'd0;
            csum_q       <= 8'd0;
            wr_en_q      <= 1'b0;
            wr_address_q <= BASE_ADDR;
            wr_data_q    <= 32'd0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_idx_q   <= word_idx_d;
            len_q        <= len_d;
            word_q       <= word_d;
            csum_q       <= csum_d;
            wr_en_q      <= wr_en_d;
            wr_address_q <= wr_address_d;
            wr_data_q    <= wr_data_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_address = wr_address_q;
    assign wr_data    = wr_data_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_text_memory_loader.sv
// Testbench for text_memory_loader: directed frames, a frame-level reference
// model compared every cycle, and literal expectations for each scenario.
`timescale 1ns/1ps
module tb_text_memory_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam longint      MAXW = 4096;

    typedef logic [7:0] bytes_t[$];

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic        wr_en;
    logic [31:0] wr_address;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    text_memory_loader dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .start      (start),
        .wr_en      (wr_en),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: interprets the frame from the list of bytes accepted
    // so far, producing what the registered outputs must be next cycle.
    logic [7:0]  hist[$];
    logic        m_wr_en   = 1'b0;
    logic [31:0] m_wr_addr = BASE;
    logic [31:0] m_wr_data = 32'd0;
    logic        m_done    = 1'b0;
    logic        m_error   = 1'b0;
    logic [1:0]  m_code    = 2'b00;
    logic        m_hold    = 1'b1;

    always @(posedge clock) begin : model
        longint idx;
        longint n;
        longint w;
        logic [7:0] sum;
        m_wr_en <= 1'b0;
        if (reset) begin
            hist.delete();
            m_wr_addr <= BASE;
            m_wr_data <= 32'd0;
            m_done    <= 1'b0;
            m_error   <= 1'b0;
            m_code    <= 2'b00;
            m_hold    <= 1'b1;
        end else if (m_done || m_error) begin
            if (start) begin
                hist.delete();
                m_done  <= 1'b0;
                m_error <= 1'b0;
                m_code  <= 2'b00;
                m_hold  <= 1'b1;
            end
        end else if (in_valid) begin
            hist.push_back(in_data);
            idx = longint'(hist.size()) - 1;
            n = 0;
            if (idx >= 3) n = longint'({hist[3], hist[2], hist[1], hist[0]});
            if (idx == 3 && n > MAXW) begin
                m_error <= 1'b1;
                m_code  <= 2'b01;
            end else if (idx >= 4 && idx < 4 + 4 * n && ((idx - 4) % 4) == 3) begin
                w = (idx - 4) / 4;
                m_wr_en   <= 1'b1;
                m_wr_addr <= BASE + 32'(4 * w);
                m_wr_data <= {hist[idx], hist[idx-1], hist[idx-2], hist[idx-3]};
            end else if (idx >= 4 && idx == 4 + 4 * n) begin
                sum = 8'd0;
                for (longint k = 4; k < idx; k++) sum = sum + hist[k];
                if (sum == hist[idx]) begin
                    m_done <= 1'b1;
                    m_hold <= 1'b0;
                end else begin
                    m_error <= 1'b1;
                    m_code  <= 2'b10;
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, !m_done});
            check("wr_en",    {31'd0, wr_en},    {31'd0, m_wr_en});
            check("wr_address", wr_address, m_wr_addr);
            check("wr_data",  wr_data, m_wr_data);
            check("cpu_hold", {31'd0, cpu_hold}, {31'd0, m_hold});
            check("done",     {31'd0, done},     {31'd0, m_done});
            check("error",    {31'd0, error},    {31'd0, m_error});
            check("err_code", {30'd0, err_code}, {30'd0, m_code});
        end
    end

    // Log of observed writes for the literal expectations.
    logic [63:0] wlog[$];
    always @(negedge clock) begin
        if (wr_en === 1'b1) wlog.push_back({wr_address, wr_data});
    end

    task automatic send(input bytes_t b, input bit stall);
        foreach (b[i]) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_data  = b[i];
            if (stall) begin
                @(negedge clock);
                in_valid = 1'b0;
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic expect_good_writes(input string tag);
        check({tag, "_nwrites"}, 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check({tag, "_w0_addr"}, wlog[0][63:32], 32'h0040_0000);
            check({tag, "_w0_data"}, wlog[0][31:0],  32'h0000_0513);
            check({tag, "_w1_addr"}, wlog[1][63:32], 32'h0040_0004);
            check({tag, "_w1_data"}, wlog[1][31:0],  32'h0010_0073);
        end
    endtask

    task automatic expect_status(input string tag, input logic d, input logic e,
                                 input logic [1:0] c, input logic h);
        check({tag, "_done"},     {31'd0, done},     {31'd0, d});
        check({tag, "_error"},    {31'd0, error},    {31'd0, e});
        check({tag, "_err_code"}, {30'd0, err_code}, {30'd0, c});
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bytes_t good, bad, oversize, empty, partial;
        good     = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
                     8'h73, 8'h00, 8'h10, 8'h00, 8'h9B};
        bad      = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
                     8'h73, 8'h00, 8'h10, 8'h00, 8'h9C};
        oversize = '{8'h01, 8'h10, 8'h00, 8'h00, 8'hAA, 8'h55, 8'h01};
        empty    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        partial  = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        start    = 1'b0;
        @(posedge clock);
        cmp_en = 1'b1;
        @(negedge clock);
        check("rst_in_ready",   {31'd0, in_ready}, 32'd1);
        check("rst_wr_en",      {31'd0, wr_en},    32'd0);
        check("rst_wr_address", wr_address, 32'h0040_0000);
        check("rst_wr_data",    wr_data,    32'd0);
        expect_status("rst", 1'b0, 1'b0, 2'b00, 1'b1);
        reset = 1'b0;

        // Good frame.
        wlog.delete();
        send(good, 1'b0);
        idle(3);
        expect_good_writes("good");
        expect_status("good", 1'b1, 1'b0, 2'b00, 1'b0);
        check("good_in_ready", {31'd0, in_ready}, 32'd0);

        // Start from DONE re-arms and raises cpu_hold.
        pulse_start();
        expect_status("rearm", 1'b0, 1'b0, 2'b00, 1'b1);

        // Bad checksum.
        wlog.delete();
        send(bad, 1'b0);
        idle(3);
        expect_good_writes("badck");
        expect_status("badck", 1'b0, 1'b1, 2'b10, 1'b1);

        // Oversize length, trailing bytes discarded.
        pulse_start();
        wlog.delete();
        send(oversize, 1'b0);
        idle(3);
        check("oversize_nwrites", 32'(wlog.size()), 32'd0);
        expect_status("oversize", 1'b0, 1'b1, 2'b01, 1'b1);
        check("oversize_in_ready", {31'd0, in_ready}, 32'd1);

        // Empty image.
        pulse_start();
        expect_status("clear_err", 1'b0, 1'b0, 2'b00, 1'b1);
        wlog.delete();
        send(empty, 1'b0);
        idle(3);
        check("empty_nwrites", 32'(wlog.size()), 32'd0);
        expect_status("empty", 1'b1, 1'b0, 2'b00, 1'b0);

        // Stalled stream.
        pulse_start();
        wlog.delete();
        send(good, 1'b1);
        idle(3);
        expect_good_writes("stall");
        expect_status("stall", 1'b1, 1'b0, 2'b00, 1'b0);

        // Reset mid-DATA after one word, then a full frame.
        pulse_start();
        send(partial, 1'b0);
        idle(1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        expect_status("midrst", 1'b0, 1'b0, 2'b00, 1'b1);
        wlog.delete();
        send(good, 1'b0);
        idle(3);
        expect_good_writes("midrst");
        expect_status("midrst_end", 1'b1, 1'b0, 2'b00, 1'b0);

        // Start from DONE followed by a second frame.
        pulse_start();
        wlog.delete();
        send(good, 1'b0);
        idle(3);
        expect_good_writes("second");
        expect_status("second", 1'b1, 1'b0, 2'b00, 1'b0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
